// File: rtl/cache_dma_pkg.sv
// Shared types and constants for the cache line transfer engine.
package cache_dma_pkg;

  localparam int LINE_BITS        = 512;
  localparam int WORD_BITS        = 32;
  localparam int ADDR_BITS        = 32;
  localparam int BEATS            = LINE_BITS / WORD_BITS;
  localparam int LINE_OFFSET_BITS = 6;
  localparam int IDX_BITS         = $clog2(BEATS);
  localparam int CNT_BITS         = IDX_BITS + 1;

  typedef logic [CNT_BITS-1:0] cnt_t;

  // Counter compare points, sized to the counters so compares stay width-clean.
  localparam cnt_t BEATS_CNT = cnt_t'(BEATS);
  localparam cnt_t LAST_BEAT = cnt_t'(BEATS - 1);

  typedef enum logic [2:0] {
    IDLE,
    EVICT_WR,
    FILL_RD,
    DONE,
    GAP
  } dma_state_e;

  // Clear the byte-in-line offset so every transfer starts on a line boundary.
  function automatic logic [ADDR_BITS-1:0] line_align(input logic [ADDR_BITS-1:0] addr);
    return {addr[ADDR_BITS-1:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/dma_line_buf.sv
// One-line staging buffer: BEATS words, whole-line load, indexed word write/read.
module dma_line_buf
  import cache_dma_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_en,
  input  logic [LINE_BITS-1:0] load_line,
  input  logic                 wr_en,
  input  logic [IDX_BITS-1:0]  wr_idx,
  input  logic [WORD_BITS-1:0] wr_data,
  input  logic [IDX_BITS-1:0]  rd_idx,
  output logic [WORD_BITS-1:0] rd_data,
  output logic [LINE_BITS-1:0] line_o
);

  logic [WORD_BITS-1:0] words_q [BEATS];

  // Whole-line load wins over a single-word write; the FSM never asserts both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this buffer is small flops, not a RAM macro, so it can be cleared on reset.
      for (int i = 0; i < BEATS; i++) words_q[i] <= '0;
    end else if (load_en) begin
      for (int i = 0; i < BEATS; i++) words_q[i] <= load_line[i*WORD_BITS +: WORD_BITS];
    end else if (wr_en) begin
      words_q[wr_idx] <= wr_data;
    end
  end

  assign rd_data = words_q[rd_idx];

  for (genvar g = 0; g < BEATS; g++) begin : g_line
    assign line_o[g*WORD_BITS +: WORD_BITS] = words_q[g];
  end

endmodule

// File: rtl/cache_line_dma.sv
// Line-transfer engine between the cache and a 32-bit req/gnt/rvalid memory bus.
// Evictions are written out as 16 ascending word beats; fills are read back the
// same way and returned as a whole line. Define CACHE_DMA_PERF_CNT_EN to add the
// fill/evict/wait performance counters.
module cache_line_dma
  import cache_dma_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [ADDR_BITS-1:0] addr_out_request_DMA_i,
  input  logic                 request_DMA_i,
  input  logic [LINE_BITS-1:0] data_out_evict_DMA_i,
  input  logic [ADDR_BITS-1:0] addr_out_evict_DMA_i,
  input  logic                 evict_DMA_i,
  output logic [LINE_BITS-1:0] data_in_request_DMA_o,
  output logic [ADDR_BITS-1:0] addr_in_request_DMA_o,
  output logic                 request_valid_DMA_o,
  output logic                 evict_DMA_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [ADDR_BITS-1:0] mem_addr_o,
  output logic [WORD_BITS-1:0] mem_wdata_o,
  input  logic                 mem_gnt_i,
  input  logic                 mem_rvalid_i,
  input  logic [WORD_BITS-1:0] mem_rdata_i
`ifdef CACHE_DMA_PERF_CNT_EN
  ,
  output logic [31:0]          fill_cnt_o,
  output logic [31:0]          evict_cnt_o,
  output logic [31:0]          mem_wait_cnt_o
`endif
);

  dma_state_e           state_q;
  logic [ADDR_BITS-1:0] base_q;
  logic                 is_fill_q;
  cnt_t                 issue_cnt_q;
  cnt_t                 rcv_cnt_q;
  logic                 mem_req_q;
  logic                 mem_we_q;
  logic                 req_valid_q;
  logic                 evict_done_q;
  logic [LINE_BITS-1:0] data_in_q;
  logic [ADDR_BITS-1:0] addr_in_q;

  logic                 beat_acc;
  logic                 buf_load;
  logic                 buf_wr;
  logic [WORD_BITS-1:0] buf_rd_data;
  logic [LINE_BITS-1:0] buf_line;
  logic [ADDR_BITS-1:0] beat_off;

  assign beat_acc = mem_req_q & mem_gnt_i;
  assign buf_load = (state_q == IDLE) & evict_DMA_i;
  assign buf_wr   = (state_q == FILL_RD) & mem_rvalid_i & (rcv_cnt_q < BEATS_CNT);
  assign beat_off = ADDR_BITS'({issue_cnt_q, 2'b00});

  dma_line_buf u_line_buf (
    .clk       (clk_i),
    .rst_n     (rst_n_i),
    .load_en   (buf_load),
    .load_line (data_out_evict_DMA_i),
    .wr_en     (buf_wr),
    .wr_idx    (rcv_cnt_q[IDX_BITS-1:0]),
    .wr_data   (mem_rdata_i),
    .rd_idx    (issue_cnt_q[IDX_BITS-1:0]),
    .rd_data   (buf_rd_data),
    .line_o    (buf_line)
  );

  // Transfer sequencing: latch the request, run the beats, pulse the ack, then idle one cycle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      base_q       <= '0;
      is_fill_q    <= 1'b0;
      issue_cnt_q  <= '0;
      rcv_cnt_q    <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      req_valid_q  <= 1'b0;
      evict_done_q <= 1'b0;
      data_in_q    <= '0;
      addr_in_q    <= '0;
    end else begin
      // NOTE: non-blocking defaults here are overridden by later assignments in
      // the case below, which is how the ack pulses stay exactly one cycle wide.
      req_valid_q  <= 1'b0;
      evict_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          issue_cnt_q <= '0;
          rcv_cnt_q   <= '0;
          if (evict_DMA_i) begin
            // Eviction first so a fill of the same line reads the written-back data.
            base_q    <= line_align(addr_out_evict_DMA_i);
            is_fill_q <= 1'b0;
            mem_req_q <= 1'b1;
            mem_we_q  <= 1'b1;
            state_q   <= EVICT_WR;
          end else if (request_DMA_i) begin
            base_q    <= line_align(addr_out_request_DMA_i);
            is_fill_q <= 1'b1;
            mem_req_q <= 1'b1;
            mem_we_q  <= 1'b0;
            state_q   <= FILL_RD;
          end
        end
        EVICT_WR: begin
          if (beat_acc) begin
            issue_cnt_q <= issue_cnt_q + cnt_t'(1);
            if (issue_cnt_q == LAST_BEAT) begin
              mem_req_q <= 1'b0;
              mem_we_q  <= 1'b0;
              state_q   <= DONE;
            end
          end
        end
        FILL_RD: begin
          if (beat_acc && issue_cnt_q < BEATS_CNT) begin
            issue_cnt_q <= issue_cnt_q + cnt_t'(1);
            if (issue_cnt_q == LAST_BEAT) mem_req_q <= 1'b0;
          end
          if (buf_wr) begin
            rcv_cnt_q <= rcv_cnt_q + cnt_t'(1);
            if (rcv_cnt_q == LAST_BEAT) state_q <= DONE;
          end
        end
        DONE: begin
          if (is_fill_q) begin
            req_valid_q <= 1'b1;
            data_in_q   <= buf_line;
            addr_in_q   <= base_q;
          end else begin
            evict_done_q <= 1'b1;
          end
          state_q <= GAP;
        end
        GAP: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req_o             = mem_req_q;
  assign mem_we_o              = mem_we_q;
  assign mem_addr_o            = mem_req_q ? (base_q + beat_off) : '0;
  assign mem_wdata_o           = (mem_req_q && mem_we_q) ? buf_rd_data : '0;
  assign request_valid_DMA_o   = req_valid_q;
  assign evict_DMA_o           = evict_done_q;
  assign data_in_request_DMA_o = data_in_q;
  assign addr_in_request_DMA_o = addr_in_q;

`ifdef CACHE_DMA_PERF_CNT_EN
  logic [31:0] fill_cnt_q;
  logic [31:0] evict_cnt_q;
  logic [31:0] mem_wait_cnt_q;

  // Free-running event counters; they wrap naturally at 2^32.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fill_cnt_q     <= '0;
      evict_cnt_q    <= '0;
      mem_wait_cnt_q <= '0;
    end else begin
      if (state_q == DONE &&  is_fill_q) fill_cnt_q  <= fill_cnt_q + 32'd1;
      if (state_q == DONE && !is_fill_q) evict_cnt_q <= evict_cnt_q + 32'd1;
      if (mem_req_q && !mem_gnt_i)       mem_wait_cnt_q <= mem_wait_cnt_q + 32'd1;
    end
  end

  assign fill_cnt_o     = fill_cnt_q;
  assign evict_cnt_o    = evict_cnt_q;
  assign mem_wait_cnt_o = mem_wait_cnt_q;
`endif

endmodule

// File: tb/tb_cache_line_dma.sv
// Self-checking bench for cache_line_dma: a word-addressed memory model with
// random grant/rvalid stalls, checked against line-level expectations.
module tb_cache_line_dma;
  import cache_dma_pkg::*;

  logic                 clk_i = 1'b0;
  logic                 rst_n_i = 1'b0;
  logic [31:0]          addr_out_request_DMA_i = '0;
  logic                 request_DMA_i = 1'b0;
  logic [511:0]         data_out_evict_DMA_i = '0;
  logic [31:0]          addr_out_evict_DMA_i = '0;
  logic                 evict_DMA_i = 1'b0;
  logic [511:0]         data_in_request_DMA_o;
  logic [31:0]          addr_in_request_DMA_o;
  logic                 request_valid_DMA_o;
  logic                 evict_DMA_o;
  logic                 mem_req_o;
  logic                 mem_we_o;
  logic [31:0]          mem_addr_o;
  logic [31:0]          mem_wdata_o;
  logic                 mem_gnt_i = 1'b0;
  logic                 mem_rvalid_i = 1'b0;
  logic [31:0]          mem_rdata_i = '0;
`ifdef CACHE_DMA_PERF_CNT_EN
  logic [31:0]          fill_cnt_o;
  logic [31:0]          evict_cnt_o;
  logic [31:0]          mem_wait_cnt_o;
`endif

  cache_line_dma dut (
    .clk_i                  (clk_i),
    .rst_n_i                (rst_n_i),
    .addr_out_request_DMA_i (addr_out_request_DMA_i),
    .request_DMA_i          (request_DMA_i),
    .data_out_evict_DMA_i   (data_out_evict_DMA_i),
    .addr_out_evict_DMA_i   (addr_out_evict_DMA_i),
    .evict_DMA_i            (evict_DMA_i),
    .data_in_request_DMA_o  (data_in_request_DMA_o),
    .addr_in_request_DMA_o  (addr_in_request_DMA_o),
    .request_valid_DMA_o    (request_valid_DMA_o),
    .evict_DMA_o            (evict_DMA_o),
    .mem_req_o              (mem_req_o),
    .mem_we_o               (mem_we_o),
    .mem_addr_o             (mem_addr_o),
    .mem_wdata_o            (mem_wdata_o),
    .mem_gnt_i              (mem_gnt_i),
    .mem_rvalid_i           (mem_rvalid_i),
    .mem_rdata_i            (mem_rdata_i)
`ifdef CACHE_DMA_PERF_CNT_EN
    ,
    .fill_cnt_o             (fill_cnt_o),
    .evict_cnt_o            (evict_cnt_o),
    .mem_wait_cnt_o         (mem_wait_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- memory model ----------------
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;

  logic [31:0] mem_m [logic [31:0]];
  logic [31:0] rd_q [$];
  beat_t       log_q [$];
  int          stall_pct   = 0;
  bit          noise       = 0;
  int          fill_pulses = 0;
  int          evict_pulses = 0;
  int          wait_cycles = 0;
  int          n_fill = 0;
  int          n_evict = 0;

  // Unwritten locations read back as a recognisable address-derived pattern.
  function automatic logic [31:0] mem_rd(input logic [31:0] addr);
    if (mem_m.exists(addr)) return mem_m[addr];
    return 32'h1000_0000 + addr;
  endfunction

  // Observe the bus mid-cycle: accepted beats, consumed read data, stalls, acks.
  always @(negedge clk_i) begin
    if (!rst_n_i) begin
      rd_q.delete();
      wait_cycles = 0;
    end else begin
      if (mem_rvalid_i && rd_q.size() > 0) void'(rd_q.pop_front());
      if (mem_req_o && mem_gnt_i) begin
        log_q.push_back('{we: mem_we_o, addr: mem_addr_o, data: mem_wdata_o});
        if (mem_we_o) mem_m[mem_addr_o] = mem_wdata_o;
        else          rd_q.push_back(mem_rd(mem_addr_o));
      end
      if (mem_req_o && !mem_gnt_i) wait_cycles++;
      if (request_valid_DMA_o) fill_pulses++;
      if (evict_DMA_o)         evict_pulses++;
    end
  end

  // Drive grant and read responses just after each rising edge.
  always @(posedge clk_i) begin
    #1;
    mem_gnt_i = ($urandom_range(99) >= stall_pct);
    if (rst_n_i && rd_q.size() > 0 && $urandom_range(99) >= stall_pct) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = rd_q[0];
    end else if (rst_n_i && noise) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = $urandom;
    end else begin
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_pulse(input bit want_fill, output int lat, output bit ok);
    lat = 0;
    ok  = 1'b0;
    @(posedge clk_i);
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk_i);
      if (want_fill ? request_valid_DMA_o : evict_DMA_o) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk_i);
      lat++;
    end
  endtask

  task automatic check_log(input int start, input logic [31:0] base, input bit we,
                           input logic [511:0] line, input string tag);
    int bad = 0;
    for (int k = 0; k < 16; k++) begin
      if (start + k >= log_q.size()) bad++;
      else if (log_q[start+k].we !== we ||
               log_q[start+k].addr !== base + 32'(4*k) ||
               (we && log_q[start+k].data !== line[32*k +: 32])) bad++;
    end
    check({tag, "_beats"}, bad, 0);
  endtask

  function automatic logic [511:0] model_line(input logic [31:0] base);
    logic [511:0] l;
    for (int k = 0; k < 16; k++) l[32*k +: 32] = mem_rd(base + 32'(4*k));
    return l;
  endfunction

  task automatic do_fill(input logic [31:0] addr, input bit chk_lat, input string tag);
    logic [31:0]  base = {addr[31:6], 6'b0};
    logic [511:0] exp_line = model_line(base);
    int start = log_q.size();
    int fp0 = fill_pulses;
    int lat;
    bit ok;
    @(posedge clk_i); #1;
    addr_out_request_DMA_i = addr;
    request_DMA_i = 1'b1;
    wait_pulse(1'b1, lat, ok);
    request_DMA_i = 1'b0;
    check({tag, "_done"}, ok, 1);
    if (chk_lat) check({tag, "_lat"}, lat, 18);
    check({tag, "_data"}, data_in_request_DMA_o, exp_line);
    check({tag, "_addr"}, addr_in_request_DMA_o, base);
    check_log(start, base, 1'b0, '0, tag);
    repeat (4) @(negedge clk_i);
    check({tag, "_nbeats"}, log_q.size() - start, 16);
    check({tag, "_pulses"}, fill_pulses - fp0, 1);
    check({tag, "_held"}, data_in_request_DMA_o, exp_line);
    if (ok) n_fill++;
  endtask

  task automatic do_evict(input logic [31:0] addr, input logic [511:0] line,
                          input bit chk_lat, input string tag);
    logic [31:0] base = {addr[31:6], 6'b0};
    int start = log_q.size();
    int ep0 = evict_pulses;
    int lat;
    bit ok;
    @(posedge clk_i); #1;
    addr_out_evict_DMA_i = addr;
    data_out_evict_DMA_i = line;
    evict_DMA_i = 1'b1;
    wait_pulse(1'b0, lat, ok);
    evict_DMA_i = 1'b0;
    check({tag, "_done"}, ok, 1);
    if (chk_lat) check({tag, "_lat"}, lat, 17);
    check_log(start, base, 1'b1, line, tag);
    repeat (4) @(negedge clk_i);
    check({tag, "_nbeats"}, log_q.size() - start, 16);
    check({tag, "_pulses"}, evict_pulses - ep0, 1);
    if (ok) n_evict++;
  endtask

  function automatic logic [511:0] rand_line();
    logic [511:0] l;
    for (int k = 0; k < 16; k++) l[32*k +: 32] = $urandom;
    return l;
  endfunction

  task automatic idle_noise();
    noise = 1'b1;
    repeat (3) @(posedge clk_i);
    noise = 1'b0;
    @(posedge clk_i);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [511:0] line;
    int           start, fp0, ep0, lat;
    bit           ok;

    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_req",   mem_req_o, 0);
    check("rst_we",    mem_we_o, 0);
    check("rst_maddr", mem_addr_o, 0);
    check("rst_wdata", mem_wdata_o, 0);
    check("rst_fv",    request_valid_DMA_o, 0);
    check("rst_ev",    evict_DMA_o, 0);
    check("rst_data",  data_in_request_DMA_o, 0);
    check("rst_addr",  addr_in_request_DMA_o, 0);
`ifdef CACHE_DMA_PERF_CNT_EN
    check("rst_perf", {fill_cnt_o, evict_cnt_o, mem_wait_cnt_o}, 0);
`endif
    rst_n_i = 1'b1;

    // Directed fill, no stalls: beats 0x1200..0x123C, 18-cycle ack.
    do_fill(32'h0000_1234, 1'b1, "fill1");

    // Directed evict: word k = k written to 0x2040 + 4k, 17-cycle ack.
    for (int k = 0; k < 16; k++) line[32*k +: 32] = 32'(k);
    do_evict(32'h0000_2040, line, 1'b1, "evict1");

    // Evict and fill of the same line raised together: writeback then read back.
    line  = rand_line();
    start = log_q.size();
    fp0   = fill_pulses;
    ep0   = evict_pulses;
    @(posedge clk_i); #1;
    addr_out_evict_DMA_i   = 32'h0000_3000;
    data_out_evict_DMA_i   = line;
    addr_out_request_DMA_i = 32'h0000_3000;
    evict_DMA_i   = 1'b1;
    request_DMA_i = 1'b1;
    wait_pulse(1'b0, lat, ok);
    evict_DMA_i = 1'b0;
    check("both_evdone", ok, 1);
    check("both_evlat", lat, 17);
    wait_pulse(1'b1, lat, ok);
    request_DMA_i = 1'b0;
    check("both_filldone", ok, 1);
    check("both_data", data_in_request_DMA_o, line);
    check("both_addr", addr_in_request_DMA_o, 32'h0000_3000);
    check_log(start, 32'h0000_3000, 1'b1, line, "both_wr");
    check_log(start + 16, 32'h0000_3000, 1'b0, '0, "both_rd");
    repeat (4) @(negedge clk_i);
    check("both_nbeats", log_q.size() - start, 32);
    check("both_fpulses", fill_pulses - fp0, 1);
    check("both_epulses", evict_pulses - ep0, 1);
    n_fill++;
    n_evict++;

    // Random traffic with 30% grant/rvalid stalls and stray rvalid while idle.
    stall_pct = 30;
    for (int i = 0; i < 10; i++) begin
      logic [31:0] a = 32'h0000_4000 + 32'($urandom_range(3) << 6) + 32'($urandom_range(63));
      idle_noise();
      if ($urandom_range(1) == 0) do_evict(a, rand_line(), 1'b0, $sformatf("rnd_ev%0d", i));
      else                        do_fill(a, 1'b0, $sformatf("rnd_fill%0d", i));
    end

`ifdef CACHE_DMA_PERF_CNT_EN
    check("perf_fill",  fill_cnt_o, n_fill);
    check("perf_evict", evict_cnt_o, n_evict);
    check("perf_wait",  mem_wait_cnt_o, wait_cycles);
`endif

    // Reset in the middle of a fill: everything clears at once, no ack follows.
    stall_pct = 0;
    start = log_q.size();
    fp0   = fill_pulses;
    @(posedge clk_i); #1;
    addr_out_request_DMA_i = 32'h0000_5000;
    request_DMA_i = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk_i);
      if (log_q.size() - start >= 8) begin
        ok = 1'b1;
        break;
      end
    end
    check("mid_reached", ok, 1);
    rst_n_i = 1'b0;
    request_DMA_i = 1'b0;
    #1;
    check("mid_req",   mem_req_o, 0);
    check("mid_maddr", mem_addr_o, 0);
    check("mid_fv",    request_valid_DMA_o, 0);
    check("mid_data",  data_in_request_DMA_o, 0);
    check("mid_addr",  addr_in_request_DMA_o, 0);
    n_fill  = 0;
    n_evict = 0;
    repeat (3) @(negedge clk_i);
    rst_n_i = 1'b1;
    repeat (25) @(negedge clk_i);
    check("mid_nopulse", fill_pulses - fp0, 0);
    do_fill(32'h0000_5000, 1'b1, "post_rst");

`ifdef CACHE_DMA_PERF_CNT_EN
    check("perf2_fill",  fill_cnt_o, n_fill);
    check("perf2_evict", evict_cnt_o, n_evict);
    check("perf2_wait",  mem_wait_cnt_o, wait_cycles);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
